// File: rtl/clint.sv
// Core-local trap sequencer: takes ecall, mret and timer interrupts at commit.
// Ports: commit (cmt_*), CSR state inputs (csr_*, *_int_*), CSR write port
// (clint_*_wen_o/wdata_o), fetch hold and redirect (clint_hold_o,
// clint_redirect_o, clint_redirect_pc_o). Sync active-high reset rst.
module clint (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmt_valid_i,
    input  logic [63:0] cmt_pc_i,
    input  logic [63:0] cmt_next_pc_i,
    input  logic        cmt_ecall_i,
    input  logic        cmt_mret_i,
    input  logic        cpu_csr_wen_i,
    input  logic [63:0] csr_mtvec_i,
    input  logic [63:0] csr_mepc_i,
    input  logic [63:0] csr_mstatus_i,
    input  logic        global_int_en_i,
    input  logic        mtime_int_en_i,
    input  logic        mtime_int_pend_i,
    output logic        clint_mepc_wen_o,
    output logic [63:0] clint_mepc_wdata_o,
    output logic        clint_mcause_wen_o,
    output logic [63:0] clint_mcause_wdata_o,
    output logic        clint_mstatus_wen_o,
    output logic [63:0] clint_mstatus_wdata_o,
    output logic        clint_hold_o,
    output logic        clint_redirect_o,
    output logic [63:0] clint_redirect_pc_o
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_REDIRECT} state_t;
    typedef enum logic [1:0] {K_INT, K_ECALL, K_MRET} kind_t;

    localparam logic [63:0] CAUSE_MTI   = 64'h8000_0000_0000_0007;
    localparam logic [63:0] CAUSE_ECALL = 64'd11;

    state_t      state, state_n;
    kind_t       kind, kind_n;
    logic [63:0] epc_q, epc_n;
    logic [63:0] cause_q, cause_n;
    logic [63:0] mstatus_q, mstatus_n;
    logic        accept;

    logic take_int, take_ecall, take_mret;
    logic [63:0] ms_trap, ms_mret;

    // Interrupt wins over ecall and mret on the same commit.
    assign take_int   = cmt_valid_i & global_int_en_i
                      & mtime_int_en_i & mtime_int_pend_i;
    assign take_ecall = cmt_valid_i & cmt_ecall_i & ~take_int;
    assign take_mret  = cmt_valid_i & cmt_mret_i & ~take_int & ~cmt_ecall_i;

    always_comb begin
        ms_trap        = csr_mstatus_i;
        ms_trap[7]     = csr_mstatus_i[3];
        ms_trap[3]     = 1'b0;
        ms_trap[12:11] = 2'b11;
        ms_mret        = csr_mstatus_i;
        ms_mret[3]     = csr_mstatus_i[7];
        ms_mret[7]     = 1'b1;
        ms_mret[12:11] = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            kind      <= K_INT;
            epc_q     <= '0;
            cause_q   <= '0;
            mstatus_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                kind      <= kind_n;
                epc_q     <= epc_n;
                cause_q   <= cause_n;
                mstatus_q <= mstatus_n;
            end
        end
    end

    always_comb begin
        state_n   = state;
        kind_n    = kind;
        epc_n     = epc_q;
        cause_n   = cause_q;
        mstatus_n = mstatus_q;
        accept    = 1'b0;
        unique case (state)
            S_IDLE: begin
                unique case (1'b1)
                    take_int: begin
                        accept    = 1'b1;
                        kind_n    = K_INT;
                        epc_n     = cmt_next_pc_i;
                        cause_n   = CAUSE_MTI;
                        mstatus_n = ms_trap;
                    end
                    take_ecall: begin
                        accept    = 1'b1;
                        kind_n    = K_ECALL;
                        epc_n     = cmt_pc_i;
                        cause_n   = CAUSE_ECALL;
                        mstatus_n = ms_trap;
                    end
                    take_mret: begin
                        accept    = 1'b1;
                        kind_n    = K_MRET;
                        mstatus_n = ms_mret;
                    end
                    default: ;
                endcase
                if (accept) state_n = S_WRITE;
            end
            // CPU CSR writes take priority in the CSR file; wait them out.
            S_WRITE:    if (!cpu_csr_wen_i) state_n = S_REDIRECT;
            S_REDIRECT: state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_comb begin
        clint_mepc_wen_o      = 1'b0;
        clint_mcause_wen_o    = 1'b0;
        clint_mstatus_wen_o   = 1'b0;
        clint_mepc_wdata_o    = '0;
        clint_mcause_wdata_o  = '0;
        clint_mstatus_wdata_o = '0;
        clint_redirect_o      = 1'b0;
        clint_redirect_pc_o   = '0;
        clint_hold_o          = (state != S_IDLE);
        if (state == S_WRITE) begin
            clint_mepc_wdata_o    = epc_q;
            clint_mcause_wdata_o  = cause_q;
            clint_mstatus_wdata_o = mstatus_q;
            clint_mstatus_wen_o   = 1'b1;
            clint_mepc_wen_o      = (kind != K_MRET);
            clint_mcause_wen_o    = (kind != K_MRET);
        end
        if (state == S_REDIRECT) begin
            clint_redirect_o = 1'b1;
            if (kind == K_MRET) clint_redirect_pc_o = csr_mepc_i;
            else                clint_redirect_pc_o = {csr_mtvec_i[63:2], 2'b00};
        end
    end

endmodule
